// File: rtl/fir_sample_sequencer_if.sv
// fir_sample_sequencer_if: enable/config, ADC, filter handshake and result bundle around the sequencer
interface fir_sample_sequencer_if #(
   parameter int BITSIZE   = 16,
   parameter int DIV_WIDTH = 16
);
   logic                 en;
   logic [DIV_WIDTH-1:0] clk_div;
   logic [BITSIZE-1:0]   adc_data;
   logic                 fir_start;
   logic [BITSIZE-1:0]   fir_din;
   logic [BITSIZE-1:0]   fir_dout;
   logic                 fir_valid;
   logic [BITSIZE-1:0]   data_out;
   logic                 data_valid;
   logic                 busy;
   logic [7:0]           overrun_cnt;
   logic                 timeout_err;
   modport master (
      output en, clk_div, adc_data, fir_dout, fir_valid,
      input  fir_start, fir_din, data_out, data_valid, busy, overrun_cnt, timeout_err
   );
   modport slave (
      input  en, clk_div, adc_data, fir_dout, fir_valid,
      output fir_start, fir_din, data_out, data_valid, busy, overrun_cnt, timeout_err
   );
endinterface

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: sample-tick divider, ADC capture and FIR start/valid handshake; FIR_SEQ_TIMEOUT_EN adds a WAIT watchdog
module fir_sample_sequencer #(
   parameter int BITSIZE   = 16,
   parameter int DIV_WIDTH = 16,
   parameter int TIMEOUT   = 64
) (
   input logic CLK,
   input logic nRST,
   fir_sample_sequencer_if.slave bus
);
   localparam logic [BITSIZE-1:0] MID = {1'b1, {(BITSIZE-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
   state_t               state;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] div_lat;
   logic                 valid_q;
   logic                 tick;
   logic                 vrise;
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("TIMEOUT must be at least 1");
   end
   assign tick     = (div_cnt == div_lat) & bus.en;
   assign vrise    = bus.fir_valid & ~valid_q;
   assign bus.busy = (state != IDLE);
`ifdef FIR_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;
   logic          to_hit;
   assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
`else
   assign bus.timeout_err = 1'b0;
`endif
   // divider, valid edge detect and the IDLE/LAUNCH/WAIT run sequencer with registered strobes
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state           <= IDLE;
         div_cnt         <= '0;
         div_lat         <= bus.clk_div;
         valid_q         <= 1'b0;
         bus.fir_start   <= 1'b0;
         bus.data_valid  <= 1'b0;
         bus.fir_din     <= MID;
         bus.data_out    <= MID;
         bus.overrun_cnt <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
         to_cnt          <= '0;
         bus.timeout_err <= 1'b0;
`endif
      end else begin
         valid_q        <= bus.fir_valid;
         bus.fir_start  <= 1'b0;
         bus.data_valid <= 1'b0;
         if (!bus.en) begin
            div_cnt <= '0;
            state   <= IDLE;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
               div_lat <= bus.clk_div;
            if (tick && state != IDLE && bus.overrun_cnt != 8'hff)
               bus.overrun_cnt <= bus.overrun_cnt + 1'b1;
            case (state)
               IDLE:
                  if (tick) begin
                     bus.fir_din   <= bus.adc_data;
                     bus.fir_start <= 1'b1;
                     state         <= LAUNCH;
                  end
               LAUNCH:
                  state <= WAIT;
               WAIT:
                  if (vrise) begin
                     bus.data_out   <= bus.fir_dout;
                     bus.data_valid <= 1'b1;
                     state          <= IDLE;
                  end
`ifdef FIR_SEQ_TIMEOUT_EN
                  else if (to_hit) begin
                     bus.timeout_err <= 1'b1;
                     state           <= IDLE;
                  end
`endif
               default:
                  state <= IDLE;
            endcase
         end
`ifdef FIR_SEQ_TIMEOUT_EN
         to_cnt <= (bus.en && state == WAIT) ? to_cnt + 1'b1 : '0;
`endif
      end
   end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer: directed checks of divider, handshake, overrun, level-held valid, EN/reset abort and timeout
module tb_fir_sample_sequencer;
   localparam int BITSIZE   = 8;
   localparam int DIV_WIDTH = 16;
   localparam int TIMEOUT   = 16;
`ifdef FIR_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   int         total = 0;
   int         bad = 0;
   int         n_start = 0;
   int         n_valid = 0;
   int         v0 = 0;
   logic       model_on = 1'b0;
   int         model_dly = 2;
   logic [7:0] m_cnt = '0;
   logic [7:0] m_dout = '0;
   logic       man_valid = 1'b0;
   logic [7:0] man_dout = '0;
   fir_sample_sequencer_if #(.BITSIZE(BITSIZE), .DIV_WIDTH(DIV_WIDTH)) bus ();
   fir_sample_sequencer #(.BITSIZE(BITSIZE), .DIV_WIDTH(DIV_WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .CLK (clk),
      .nRST(nrst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   assign bus.fir_valid = model_on ? (m_cnt == 8'd1) : man_valid;
   assign bus.fir_dout  = model_on ? m_dout : man_dout;
   // filter model: answers FIR_DIN+1 with a one-cycle valid model_dly cycles after it samples start
   always @(posedge clk) begin
      if (!model_on)
         m_cnt <= '0;
      else if (bus.fir_start) begin
         m_cnt  <= 8'(model_dly);
         m_dout <= bus.fir_din + 8'd1;
      end else if (m_cnt != 0)
         m_cnt <= m_cnt - 8'd1;
   end
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         n_start += int'(bus.fir_start);
         n_valid += int'(bus.data_valid);
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.en       = 1'b0;
      bus.clk_div  = 16'd7;
      bus.adc_data = 8'h40;
      step(3);
      chk("rst_data_out", 32'(bus.data_out), 32'h80);
      chk("rst_fir_din", 32'(bus.fir_din), 32'h80);
      chk("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
      chk("rst_fir_start", 32'(bus.fir_start), 32'd0);
      chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      model_on  = 1'b1;
      model_dly = 2;
      nrst      = 1'b1;
      bus.en    = 1'b1;
      step(7);
      chk("nom_pre_start", 32'(bus.fir_start), 32'd0);
      chk("nom_pre_busy", 32'(bus.busy), 32'd0);
      step(1);
      chk("nom_start", 32'(bus.fir_start), 32'd1);
      chk("nom_fir_din", 32'(bus.fir_din), 32'h40);
      chk("nom_busy", 32'(bus.busy), 32'd1);
      step(1);
      chk("nom_start_1cyc", 32'(bus.fir_start), 32'd0);
      chk("nom_wait_busy", 32'(bus.busy), 32'd1);
      step(1);
      chk("nom_no_valid_yet", 32'(bus.data_valid), 32'd0);
      step(1);
      chk("nom_valid", 32'(bus.data_valid), 32'd1);
      chk("nom_data_out", 32'(bus.data_out), 32'h41);
      chk("nom_idle_busy", 32'(bus.busy), 32'd0);
      bus.adc_data = 8'h55;
      step(1);
      chk("nom_valid_1cyc", 32'(bus.data_valid), 32'd0);
      chk("nom_hold_out", 32'(bus.data_out), 32'h41);
      step(3);
      chk("nom_start2_pre", 32'(bus.fir_start), 32'd0);
      step(1);
      chk("nom_start2_period8", 32'(bus.fir_start), 32'd1);
      chk("nom_fir_din2", 32'(bus.fir_din), 32'h55);
      step(3);
      chk("nom_valid2", 32'(bus.data_valid), 32'd1);
      chk("nom_data_out2", 32'(bus.data_out), 32'h56);
      chk("nom_overrun0", 32'(bus.overrun_cnt), 32'd0);
      bus.clk_div  = 16'd3;
      bus.adc_data = 8'h10;
      model_dly    = 10;
      step(16);
      chk("ovr_valid", 32'(bus.data_valid), 32'd1);
      chk("ovr_data_out", 32'(bus.data_out), 32'h11);
      chk("ovr_count2", 32'(bus.overrun_cnt), 32'd2);
      step(1700);
      chk("ovr_saturated", 32'(bus.overrun_cnt), 32'd255);
      bus.clk_div = 16'd200;
      step(20);
      chk("ovr_all_delivered", 32'(n_valid), 32'(n_start));
      chk("ovr_many_runs", 32'(n_valid > 100), 32'd1);
      model_on     = 1'b0;
      man_valid    = 1'b0;
      bus.clk_div  = 16'd5;
      bus.adc_data = 8'h22;
      nrst         = 1'b0;
      step(1);
      nrst = 1'b1;
      step(6);
      chk("lvl_start", 32'(bus.fir_start), 32'd1);
      chk("lvl_fir_din", 32'(bus.fir_din), 32'h22);
      step(2);
      man_valid = 1'b1;
      man_dout  = 8'h33;
      step(1);
      chk("lvl_first_valid", 32'(bus.data_valid), 32'd1);
      chk("lvl_first_out", 32'(bus.data_out), 32'h33);
      v0 = n_valid;
      step(8);
      chk("lvl_held_busy", 32'(bus.busy), 32'd1);
      chk("lvl_held_no_valid", 32'(n_valid), 32'(v0));
      chk("lvl_held_out", 32'(bus.data_out), 32'h33);
      man_valid = 1'b0;
      man_dout  = 8'h44;
      step(1);
      chk("lvl_low_no_valid", 32'(bus.data_valid), 32'd0);
      man_valid = 1'b1;
      step(1);
      chk("lvl_second_valid", 32'(bus.data_valid), 32'd1);
      chk("lvl_second_out", 32'(bus.data_out), 32'h44);
      chk("lvl_overrun1", 32'(bus.overrun_cnt), 32'd1);
      man_valid = 1'b0;
      step(5);
      chk("en_start", 32'(bus.fir_start), 32'd1);
      step(2);
      chk("en_wait_busy", 32'(bus.busy), 32'd1);
      v0     = n_valid;
      bus.en = 1'b0;
      step(1);
      chk("en_off_busy", 32'(bus.busy), 32'd0);
      man_valid = 1'b1;
      step(1);
      chk("en_off_no_valid", 32'(n_valid), 32'(v0));
      chk("en_off_hold_out", 32'(bus.data_out), 32'h44);
      chk("en_off_hold_din", 32'(bus.fir_din), 32'h22);
      bus.en    = 1'b1;
      man_valid = 1'b0;
      step(5);
      chk("en_re_pre_start", 32'(bus.fir_start), 32'd0);
      step(1);
      chk("en_re_start", 32'(bus.fir_start), 32'd1);
      step(16);
      chk("to_pre_busy", 32'(bus.busy), 32'd1);
      chk("to_pre_err", 32'(bus.timeout_err), 32'd0);
      step(1);
      chk("to_busy", 32'(bus.busy), 32'(!TO_EN));
      chk("to_err", 32'(bus.timeout_err), 32'(TO_EN));
      chk("to_no_valid", 32'(bus.data_valid), 32'd0);
      chk("to_hold_out", 32'(bus.data_out), 32'h44);
      step(1);
      chk("to_relaunch", 32'(bus.fir_start), 32'(TO_EN));
      chk("to_err_sticky", 32'(bus.timeout_err), 32'(TO_EN));
      nrst = 1'b0;
      step(1);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_start", 32'(bus.fir_start), 32'd0);
      chk("mrst_data_out", 32'(bus.data_out), 32'h80);
      chk("mrst_fir_din", 32'(bus.fir_din), 32'h80);
      chk("mrst_overrun", 32'(bus.overrun_cnt), 32'd0);
      chk("mrst_timeout_err", 32'(bus.timeout_err), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
